// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Optional feature macro: FIFO_WARB_BURST_EN (see fifo_wr_arbiter.sv).
package fifo_arb_pkg;

    // Output-beat FSM: IDLE = no beat held, BUSY = beat offered to the FIFO,
    // FULL = beat held back by a full FIFO.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FULL = 2'd2
    } state_t;

    // Index width for a requester count; never below 1 bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester handshake plus FIFO write-port signals of the write arbiter.
// master: the requesters and the FIFO; slave: the arbiter itself.
interface fifo_wr_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 8
);
    import fifo_arb_pkg::*;

    localparam int GNT_W = clog2(NREQ);

    logic [NREQ-1:0]        i_req_valid;
    logic [NREQ*DATA_W-1:0] i_req_data;
    logic [NREQ-1:0]        o_req_ready;
    logic                   i_wfull;
    logic                   o_winc;
    logic [DATA_W-1:0]      o_wdata;
    logic [GNT_W-1:0]       o_gnt_id;
    logic                   o_busy;

    modport master (
        output i_req_valid,
        output i_req_data,
        output i_wfull,
        input  o_req_ready,
        input  o_winc,
        input  o_wdata,
        input  o_gnt_id,
        input  o_busy
    );

    modport slave (
        input  i_req_valid,
        input  i_req_data,
        input  i_wfull,
        output o_req_ready,
        output o_winc,
        output o_wdata,
        output o_gnt_id,
        output o_busy
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first valid requester at or after ptr,
// wrapping NREQ-1 -> 0. Produces a one-hot grant, its index and an any flag.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int GNT_W = 2
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [GNT_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [GNT_W-1:0] winner,
    output logic             any
);

    // ptr + offset modulo NREQ; ptr is always below NREQ so one subtraction suffices.
    function automatic logic [GNT_W-1:0] wrap_add(input logic [GNT_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return GNT_W'(sum);
    endfunction

    // Scan from the pointer outward; the first hit wins and later hits are ignored.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        for (int offset = 0; offset < NREQ; offset++) begin
            if (!any && valid[wrap_add(ptr, offset)]) begin
                any                          = 1'b1;
                winner                       = wrap_add(ptr, offset);
                grant[wrap_add(ptr, offset)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the single async-FIFO write port among NREQ write-domain requesters.
// Round-robin grant, one registered output beat (o_winc/o_wdata) that waits out i_wfull.
// Optional feature macro: FIFO_WARB_BURST_EN -- when defined the granted requester keeps
// priority for up to BURST_LEN (1..7) consecutive beats; otherwise the pointer advances
// after every accepted beat and BURST_LEN is ignored.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
) (
    input  logic            i_wclk,
    input  logic            i_wrst_n,
    fifo_wr_arbiter_if.slave bus
);

    localparam int GNT_W = clog2(NREQ);

    state_t            state;
    state_t            state_nxt;
    logic [GNT_W-1:0]  ptr;
    logic [GNT_W-1:0]  ptr_nxt;
    logic [NREQ-1:0]   grant;
    logic [GNT_W-1:0]  winner;
    logic              any_valid;
    logic              winc;
    logic              load_en;
    logic              accept;
    logic [NREQ-1:0]   ready;
    logic [DATA_W-1:0] wdata_q;
    logic [GNT_W-1:0]  gnt_q;

    // Index following idx, wrapping NREQ-1 -> 0.
    function automatic logic [GNT_W-1:0] next_idx(input logic [GNT_W-1:0] idx);
        return (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
    endfunction

    rr_arbiter #(
        .NREQ  (NREQ),
        .GNT_W (GNT_W)
    ) u_rr_arbiter (
        .valid  (bus.i_req_valid),
        .ptr    (ptr),
        .grant  (grant),
        .winner (winner),
        .any    (any_valid)
    );

    // A beat is held whenever the FSM is out of IDLE; the output register can take a new
    // beat when it is empty or its current beat is written this cycle.
    assign winc    = (state != S_IDLE);
    assign load_en = !winc || !bus.i_wfull;

    // Ready is masked during reset so a requester holding valid is never accepted then.
    assign ready  = grant & {NREQ{load_en & i_wrst_n}};
    assign accept = any_valid & load_en & i_wrst_n;

    assign bus.o_req_ready = ready;
    assign bus.o_winc      = winc;
    assign bus.o_busy      = winc;
    assign bus.o_wdata     = wdata_q;
    assign bus.o_gnt_id    = gnt_q;

    // Next state of the output-beat FSM.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.i_wfull) begin
                    state_nxt = S_FULL;
                end else if (!accept) begin
                    state_nxt = S_IDLE;
                end
            end
            S_FULL: begin
                if (!bus.i_wfull) begin
                    state_nxt = accept ? S_BUSY : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_wclk or negedge i_wrst_n) begin
        if (!i_wrst_n) begin
            state <= S_IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignment so every register samples pre-edge values.
            state <= state_nxt;
        end
    end

    // Output beat register: loads only on accept, otherwise holds data and owner so a
    // stalled or drained beat keeps its value.
    always_ff @(posedge i_wclk or negedge i_wrst_n) begin
        if (!i_wrst_n) begin
            wdata_q <= '0;
            gnt_q   <= '0;
        end else if (accept) begin
            wdata_q <= bus.i_req_data[int'(winner)*DATA_W +: DATA_W];
            gnt_q   <= winner;
        end
    end

`ifdef FIFO_WARB_BURST_EN
    localparam logic [2:0] BURST_MAX = 3'(BURST_LEN);

    logic [2:0] burst_cnt;
    logic [2:0] burst_cnt_nxt;

    // Burst bookkeeping: the count restarts at 1 on a new owner (or after a full burst);
    // the pointer stays on the owner until the burst is used up, then moves past it.
    // An owner that drops valid is skipped by the arbiter scan, handing over at once.
    always_comb begin
        burst_cnt_nxt = burst_cnt;
        ptr_nxt       = ptr;
        if (accept) begin
            if (winner != gnt_q || burst_cnt == 3'd0 || burst_cnt >= BURST_MAX) begin
                burst_cnt_nxt = 3'd1;
            end else begin
                burst_cnt_nxt = burst_cnt + 3'd1;
            end
            ptr_nxt = (burst_cnt_nxt >= BURST_MAX) ? next_idx(winner) : winner;
        end
    end

    // Burst counter register.
    always_ff @(posedge i_wclk or negedge i_wrst_n) begin
        if (!i_wrst_n) begin
            burst_cnt <= 3'd0;
        end else begin
            burst_cnt <= burst_cnt_nxt;
        end
    end
`else
    // Strict per-beat round robin: the pointer moves past every accepted requester.
    always_comb begin
        ptr_nxt = ptr;
        if (accept) begin
            ptr_nxt = next_idx(winner);
        end
    end
`endif

    // Round-robin pointer register; it only changes on an accept.
    always_ff @(posedge i_wclk or negedge i_wrst_n) begin
        if (!i_wrst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter. Requesters are modelled as per-port beat queues;
// expected FIFO writes go into a scoreboard queue and a monitor compares every write.
// Expectations for FIFO_WARB_BURST_EN builds are selected with the same macro.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int NREQ   = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } beat_t;

    logic i_wclk = 1'b0;
    logic i_wrst_n;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W)) bus ();

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .DATA_W    (DATA_W),
        .BURST_LEN (4)
    ) dut (
        .i_wclk   (i_wclk),
        .i_wrst_n (i_wrst_n),
        .bus      (bus)
    );

    always #5 i_wclk = ~i_wclk;

    beat_t      exp_q[$];
    logic [7:0] rq_mem[NREQ][DEPTH];
    int         rq_head[NREQ];
    int         rq_tail[NREQ];
    int         vid[$];
    logic [7:0] vd[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         wr_count = 0;
    int         wr_before;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic load(input int k, input logic [7:0] d);
        rq_mem[k][rq_tail[k]] = d;
        rq_tail[k]++;
    endtask

    task automatic expect_wr(input int k, input logic [7:0] d);
        exp_q.push_back({2'(k), d});
    endtask

    // Each requester presents the head of its queue and holds it until accepted.
    task automatic drive_inputs();
        for (int k = 0; k < NREQ; k++) begin
            bus.i_req_valid[k] = (rq_head[k] < rq_tail[k]);
            bus.i_req_data[k*DATA_W +: DATA_W] = (rq_head[k] < rq_tail[k]) ? rq_mem[k][rq_head[k]] : 8'h00;
        end
    endtask

    // One clock: note the accepts before the edge, retire those beats after it,
    // and return 2 time units past the edge with inputs settled.
    task automatic cycle();
        logic [NREQ-1:0] acc;
        @(negedge i_wclk);
        acc = bus.i_req_valid & bus.o_req_ready;
        @(posedge i_wclk);
        #1;
        for (int k = 0; k < NREQ; k++) begin
            if (acc[k]) rq_head[k]++;
        end
        drive_inputs();
        #1;
    endtask

    // Push the expected writes listed in vid/vd, then step once per beat and check the
    // output register holds each beat the cycle after it is accepted.
    task automatic run_vec(input string name);
        for (int i = 0; i < vid.size(); i++) expect_wr(vid[i], vd[i]);
        for (int i = 0; i < vid.size(); i++) begin
            cycle();
            check({name, "_gnt"}, 32'(bus.o_gnt_id), 32'(vid[i]));
            check({name, "_wdata"}, 32'(bus.o_wdata), 32'(vd[i]));
            check({name, "_winc"}, 32'(bus.o_winc), 32'd1);
        end
    endtask

    // One cycle with no new accept: the pending beat drains and the data holds.
    task automatic drain(input string name, input logic [7:0] last);
        cycle();
        check({name, "_winc"}, 32'(bus.o_winc), 32'd0);
        check({name, "_busy"}, 32'(bus.o_busy), 32'd0);
        check({name, "_hold"}, 32'(bus.o_wdata), 32'(last));
    endtask

    // Scoreboard monitor: a write happens on the next edge when o_winc=1 and i_wfull=0.
    initial begin
        beat_t e;
        forever begin
            @(negedge i_wclk);
            if (i_wrst_n === 1'b1 && bus.o_winc === 1'b1 && bus.i_wfull === 1'b0) begin
                wr_count++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got id=%0d data=0x%02h, required no write (t=%0t)",
                             bus.o_gnt_id, bus.o_wdata, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_id", 32'(bus.o_gnt_id), 32'(e.id));
                    check("wr_data", 32'(bus.o_wdata), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got no end of test, required completion within 20000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_wrst_n        = 1'b0;
        bus.i_wfull     = 1'b0;
        bus.i_req_valid = '0;
        bus.i_req_data  = '0;
        for (int k = 0; k < NREQ; k++) begin
            rq_head[k] = 0;
            rq_tail[k] = 0;
        end

        // Test 1: reset with every requester valid.
        load(0, 8'hA0); load(0, 8'hA1);
        load(1, 8'hB0); load(2, 8'hC0); load(3, 8'hD0);
        drive_inputs();
        repeat (3) @(posedge i_wclk);
        #2;
        check("rst_ready", 32'(bus.o_req_ready), 32'h0);
        check("rst_winc", 32'(bus.o_winc), 32'd0);
        check("rst_wdata", 32'(bus.o_wdata), 32'h0);
        check("rst_gnt", 32'(bus.o_gnt_id), 32'd0);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        i_wrst_n = 1'b1;
        #1;
        check("rel_ready", 32'(bus.o_req_ready), 32'b0001);

        // Test 2: all four valid, one beat per cycle.
`ifdef FIFO_WARB_BURST_EN
        vid = '{0, 0, 1, 2, 3};
        vd  = '{8'hA0, 8'hA1, 8'hB0, 8'hC0, 8'hD0};
`else
        vid = '{0, 1, 2, 3, 0};
        vd  = '{8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hA1};
`endif
        run_vec("t2");
        drain("t2_drain", vd[vd.size()-1]);

        // Test 3: FIFO full for three cycles with a beat pending.
        load(1, 8'h51); load(2, 8'h52);
        drive_inputs();
        #1;
        check("t3_ready_pre", 32'(bus.o_req_ready), 32'b0010);
        expect_wr(1, 8'h51);
        expect_wr(2, 8'h52);
        cycle();
        check("t3_wdata", 32'(bus.o_wdata), 32'h51);
        bus.i_wfull = 1'b1;
        #1;
        check("t3_ready_full", 32'(bus.o_req_ready), 32'h0);
        wr_before = wr_count;
        repeat (3) begin
            cycle();
            check("t3_full_winc", 32'(bus.o_winc), 32'd1);
            check("t3_full_wdata", 32'(bus.o_wdata), 32'h51);
            check("t3_full_ready", 32'(bus.o_req_ready), 32'h0);
            check("t3_full_busy", 32'(bus.o_busy), 32'd1);
        end
        check("t3_no_write", 32'(wr_count), 32'(wr_before));
        bus.i_wfull = 1'b0;
        #1;
        check("t3_ready_rel", 32'(bus.o_req_ready), 32'b0100);
        cycle();
        check("t3_one_write", 32'(wr_count), 32'(wr_before + 1));
        check("t3_next_gnt", 32'(bus.o_gnt_id), 32'd2);
        check("t3_next_wdata", 32'(bus.o_wdata), 32'h52);
        drain("t3_drain", 8'h52);
        check("t3_two_writes", 32'(wr_count), 32'(wr_before + 2));

        // Test 4: only requester 2, then requester 3, then 0 and 3 together.
        load(2, 8'h60); load(2, 8'h61); load(2, 8'h62);
        drive_inputs();
        vid = '{2, 2, 2};
        vd  = '{8'h60, 8'h61, 8'h62};
        run_vec("t4a");
        load(3, 8'h63);
        drive_inputs();
        vid = '{3};
        vd  = '{8'h63};
        run_vec("t4b");
        load(0, 8'h64); load(3, 8'h65);
        drive_inputs();
`ifdef FIFO_WARB_BURST_EN
        vid = '{3, 0};
        vd  = '{8'h65, 8'h64};
`else
        vid = '{0, 3};
        vd  = '{8'h64, 8'h65};
`endif
        run_vec("t4c");
        drain("t4_drain", vd[vd.size()-1]);

        // Test 5: requesters 1 and 3 valid; requester 1 stops after six beats.
        for (int i = 0; i < 6; i++) load(1, 8'(8'h10 + i));
        for (int i = 0; i < 7; i++) load(3, 8'(8'h30 + i));
        drive_inputs();
`ifdef FIFO_WARB_BURST_EN
        vid = '{1, 1, 1, 1, 3, 3, 3, 3, 1, 1, 3, 3, 3};
        vd  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h30, 8'h31, 8'h32, 8'h33,
                8'h14, 8'h15, 8'h34, 8'h35, 8'h36};
`else
        vid = '{1, 3, 1, 3, 1, 3, 1, 3, 1, 3, 1, 3, 3};
        vd  = '{8'h10, 8'h30, 8'h11, 8'h31, 8'h12, 8'h32, 8'h13, 8'h33,
                8'h14, 8'h34, 8'h15, 8'h35, 8'h36};
`endif
        run_vec("t5");
        drain("t5_drain", 8'h36);

        // Test 6: reset while the beat is stuck behind a full FIFO.
        load(0, 8'h70);
        drive_inputs();
        #1;
        check("t6_ready", 32'(bus.o_req_ready), 32'b0001);
        cycle();
        check("t6_wdata", 32'(bus.o_wdata), 32'h70);
        bus.i_wfull = 1'b1;
        #1;
        cycle();
        check("t6_full_busy", 32'(bus.o_busy), 32'd1);
        #1;
        i_wrst_n = 1'b0;
        #1;
        check("t6_rst_winc", 32'(bus.o_winc), 32'd0);
        check("t6_rst_wdata", 32'(bus.o_wdata), 32'h0);
        check("t6_rst_gnt", 32'(bus.o_gnt_id), 32'd0);
        check("t6_rst_busy", 32'(bus.o_busy), 32'd0);
        wr_before   = wr_count;
        bus.i_wfull = 1'b0;
        repeat (2) cycle();
        i_wrst_n = 1'b1;
        #1;
        check("t6_rel_ready", 32'(bus.o_req_ready), 32'h0);
        repeat (3) begin
            cycle();
            check("t6_idle_winc", 32'(bus.o_winc), 32'd0);
        end
        check("t6_no_write", 32'(wr_count), 32'(wr_before));
        load(2, 8'h72);
        drive_inputs();
        #1;
        check("t6_new_ready", 32'(bus.o_req_ready), 32'b0100);
        vid = '{2};
        vd  = '{8'h72};
        run_vec("t6");
        drain("t6_drain", 8'h72);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
